// File: rtl/prog_ctr_pkg.sv
// Shared types and constants for the program-counter stage.
// The optional performance counters are enabled by defining PROG_CTR_PERF_EN.
package prog_ctr_pkg;

  // Sequencing states of the core front end.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  // Default PC / offset width in bits.
  localparam int PC_W = 12;

  // Sequential advance per instruction.
  localparam int PC_INC = 1;

endpackage : prog_ctr_pkg

// File: rtl/prog_ctr_fsm_pc_next_calc.sv
// Combinational next-PC selection for the program-counter stage.
// Chooses between hold, sequential increment, PC-relative taken branch and
// reload of START_ADDR, and flags when a taken branch is actually applied.
module pc_next_calc
  import prog_ctr_pkg::*;
#(
  parameter int               WIDTH      = PC_W,
  parameter logic [WIDTH-1:0] START_ADDR = '0
) (
  input  pc_state_t        state,
  input  logic             start,
  input  logic             stall,
  input  logic             branch_en,
  input  logic             taken,
  input  logic             halt,
  input  logic [WIDTH-1:0] prog_ctr,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] next_pc,
  output logic             br_apply
);

  // Next-PC mux: stall beats halt beats taken branch beats increment.
  // Additions are WIDTH bits wide so the carry drops out (modulo wrap).
  always_comb begin
    next_pc  = prog_ctr;
    br_apply = 1'b0;
    case (state)
      IDLE: begin
        next_pc = START_ADDR;
      end
      RUN: begin
        if (!stall && !halt) begin
          if (branch_en && taken) begin
            next_pc  = prog_ctr + target;
            br_apply = 1'b1;
          end else begin
            next_pc = prog_ctr + WIDTH'(PC_INC);
          end
        end
      end
      HALT: begin
        if (start) begin
          next_pc = START_ADDR;
        end
      end
      default: begin
        next_pc = START_ADDR;
      end
    endcase
  end

endmodule : pc_next_calc

// File: rtl/prog_ctr_fsm.sv
// Program-counter stage: holds the fetch address, steps it per instruction,
// applies PC-relative taken branches and sequences IDLE/RUN/HALT.
// Define PROG_CTR_PERF_EN to add the cycle_cnt / br_taken_cnt counters.
module prog_ctr_fsm
  import prog_ctr_pkg::*;
#(
  parameter int               WIDTH      = PC_W,
  parameter logic [WIDTH-1:0] START_ADDR = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stall,
  input  logic             branch_en,
  input  logic             taken,
  input  logic [WIDTH-1:0] target,
  input  logic             halt,
`ifdef PROG_CTR_PERF_EN
  output logic [31:0]      cycle_cnt,
  output logic [15:0]      br_taken_cnt,
`endif
  output logic [WIDTH-1:0] prog_ctr,
  output logic             running,
  output logic             done
);

  pc_state_t        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             br_apply;
  logic             start_accept;

  // A start is only honoured outside RUN; it also clears the counters.
  assign start_accept = (state_q != RUN) && start;

  pc_next_calc #(
    .WIDTH      (WIDTH),
    .START_ADDR (START_ADDR)
  ) u_pc_next_calc (
    .state     (state_q),
    .start     (start),
    .stall     (stall),
    .branch_en (branch_en),
    .taken     (taken),
    .halt      (halt),
    .prog_ctr  (pc_q),
    .target    (target),
    .next_pc   (pc_d),
    .br_apply  (br_apply)
  );

  // Next-state logic for the run sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (!stall && halt) state_d = HALT;
      HALT:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= START_ADDR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign prog_ctr = pc_q;
  assign running  = (state_q == RUN);
  assign done     = (state_q == HALT);

`ifdef PROG_CTR_PERF_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [15:0] br_cnt_q, br_cnt_d;

  // Saturating counters: RUN edges (stalls included) and applied branches.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    br_cnt_d    = br_cnt_q;
    if (start_accept) begin
      cycle_cnt_d = '0;
      br_cnt_d    = '0;
    end else begin
      if (state_q == RUN && cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + 32'd1;
      if (br_apply && br_cnt_q != '1)          br_cnt_d    = br_cnt_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      br_cnt_q    <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      br_cnt_q    <= br_cnt_d;
    end
  end

  assign cycle_cnt    = cycle_cnt_q;
  assign br_taken_cnt = br_cnt_q;
`else
  // Without the counters, accepted starts and applied branches have no
  // further consumer; fold them into a dummy so they stay intentionally used.
  logic unused_perf;
  assign unused_perf = start_accept ^ br_apply;
`endif

endmodule : prog_ctr_fsm

// File: tb/tb_prog_ctr_fsm.sv
// Self-checking bench for prog_ctr_fsm (optionally with PROG_CTR_PERF_EN).
module tb_prog_ctr_fsm;

  localparam int W   = 12;
  localparam int MOD = 1 << W;
  localparam logic [W-1:0] START = 12'h000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         stall = 1'b0;
  logic         branch_en = 1'b0;
  logic         taken = 1'b0;
  logic         halt = 1'b0;
  logic [W-1:0] target = '0;
  logic [W-1:0] prog_ctr;
  logic         running;
  logic         done;
`ifdef PROG_CTR_PERF_EN
  logic [31:0]  cycle_cnt;
  logic [15:0]  br_taken_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int txn = 0;

  // Reference model: 0=idle, 1=run, 2=halt; PC kept as a plain integer.
  int      m_state = 0;
  int      m_pc = 0;
  longint  m_cyc = 0;
  int      m_br = 0;

  always #5 clk = ~clk;

  prog_ctr_fsm #(
    .WIDTH      (W),
    .START_ADDR (START)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stall        (stall),
    .branch_en    (branch_en),
    .taken        (taken),
    .target       (target),
    .halt         (halt),
`ifdef PROG_CTR_PERF_EN
    .cycle_cnt    (cycle_cnt),
    .br_taken_cnt (br_taken_cnt),
`endif
    .prog_ctr     (prog_ctr),
    .running      (running),
    .done         (done)
  );

  // Drive one cycle of inputs, clock it, and advance the model.
  task automatic step(input logic s, input logic st, input logic be,
                      input logic tk, input logic [W-1:0] tg, input logic h);
    start = s; stall = st; branch_en = be; taken = tk; target = tg; halt = h;
    @(posedge clk);
    #1;
    case (m_state)
      0: if (s) begin m_state = 1; m_pc = int'(START); m_cyc = 0; m_br = 0; end
      1: begin
        if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
        if (st) begin
        end else if (h) begin
          m_state = 2;
        end else if (be && tk) begin
          m_pc = (m_pc + int'(tg)) % MOD;
          if (m_br < 16'hFFFF) m_br++;
        end else begin
          m_pc = (m_pc + 1) % MOD;
        end
      end
      default: if (s) begin m_state = 1; m_pc = int'(START); m_cyc = 0; m_br = 0; end
    endcase
    txn++;
    $display("txn %0d: start=%b stall=%b br=%b tk=%b tgt=%h halt=%b -> pc=%h run=%b done=%b",
             txn, s, st, be, tk, tg, h, prog_ctr, running, done);
  endtask

  // Force the PC to a chosen value with a taken branch (model must be in RUN).
  task automatic set_pc(input int want);
    logic [W-1:0] off;
    off = W'((want - m_pc + MOD) % MOD);
    step(1'b0, 1'b0, 1'b1, 1'b1, off, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (prog_ctr !== 12'h000) begin errors++; $display("FAIL reset_pc: got %h want 000", prog_ctr); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    @(negedge clk) rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    checks++; if (prog_ctr !== 12'h000 || running !== 1'b0) begin errors++; $display("FAIL idle_hold: got pc=%h run=%b want 000/0", prog_ctr, running); end
  endtask

  task automatic test_start_seq;
    logic [W-1:0] exp_seq [4];
    exp_seq[0] = 12'h000; exp_seq[1] = 12'h001; exp_seq[2] = 12'h002; exp_seq[3] = 12'h003;
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_running: got %b want 1", running); end
    checks++; if (prog_ctr !== exp_seq[0]) begin errors++; $display("FAIL start_pc0: got %h want %h", prog_ctr, exp_seq[0]); end
    for (int i = 1; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      checks++; if (prog_ctr !== exp_seq[i]) begin errors++; $display("FAIL seq_pc%0d: got %h want %h", i, prog_ctr, exp_seq[i]); end
    end
    // start is ignored while running
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    checks++; if (prog_ctr !== 12'h004) begin errors++; $display("FAIL start_in_run: got %h want 004", prog_ctr); end
  endtask

  task automatic test_branches;
    set_pc(10);
    step(1'b0, 1'b0, 1'b1, 1'b1, 12'hFFB, 1'b0);
    checks++; if (prog_ctr !== 12'h005) begin errors++; $display("FAIL br_back: got %h want 005", prog_ctr); end
    set_pc(10);
    step(1'b0, 1'b0, 1'b1, 1'b0, 12'hFFB, 1'b0);
    checks++; if (prog_ctr !== 12'h00B) begin errors++; $display("FAIL br_not_taken: got %h want 00b", prog_ctr); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 12'h100, 1'b0);
    checks++; if (prog_ctr !== 12'h00C) begin errors++; $display("FAIL taken_no_br: got %h want 00c", prog_ctr); end
    set_pc(4);
    step(1'b0, 1'b0, 1'b1, 1'b1, 12'd20, 1'b0);
    checks++; if (prog_ctr !== 12'd24) begin errors++; $display("FAIL br_fwd: got %h want 018", prog_ctr); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0);
      checks++; if (prog_ctr !== 12'd24) begin errors++; $display("FAIL br_spin%0d: got %h want 018", i, prog_ctr); end
    end
    set_pc(4);
    step(1'b0, 1'b0, 1'b1, 1'b1, 12'hFFF, 1'b0);
    checks++; if (prog_ctr !== 12'h003) begin errors++; $display("FAIL br_minus1: got %h want 003", prog_ctr); end
  endtask

  task automatic test_wrap;
    set_pc(12'hFFF);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    checks++; if (prog_ctr !== 12'h000) begin errors++; $display("FAIL wrap_inc: got %h want 000", prog_ctr); end
    set_pc(2);
    step(1'b0, 1'b0, 1'b1, 1'b1, 12'hFFB, 1'b0);
    checks++; if (prog_ctr !== 12'hFFD) begin errors++; $display("FAIL wrap_br: got %h want ffd", prog_ctr); end
  endtask

  task automatic test_priority;
    set_pc(12'h200);
    step(1'b1, 1'b1, 1'b1, 1'b1, 12'h010, 1'b1);
    checks++; if (prog_ctr !== 12'h200 || running !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL stall_prio: got pc=%h run=%b done=%b want 200/1/0", prog_ctr, running, done); end
    step(1'b0, 1'b0, 1'b1, 1'b1, 12'h010, 1'b1);
    checks++; if (prog_ctr !== 12'h200 || running !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL halt_prio: got pc=%h run=%b done=%b want 200/0/1", prog_ctr, running, done); end
    step(1'b0, 1'b1, 1'b1, 1'b1, 12'h010, 1'b0);
    checks++; if (prog_ctr !== 12'h200 || done !== 1'b1) begin
      errors++; $display("FAIL halt_frozen: got pc=%h done=%b want 200/1", prog_ctr, done); end
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    checks++; if (prog_ctr !== 12'h000 || running !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL restart: got pc=%h run=%b done=%b want 000/1/0", prog_ctr, running, done); end
  endtask

  task automatic test_async_reset;
    set_pc(12'h123);
    start = 1'b0; stall = 1'b0; branch_en = 1'b1; taken = 1'b1; target = 12'h055; halt = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    m_state = 0; m_pc = int'(START); m_cyc = 0; m_br = 0;
    checks++; if (prog_ctr !== 12'h000 || running !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL async_reset: got pc=%h run=%b done=%b want 000/0/0", prog_ctr, running, done); end
    @(negedge clk) rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    checks++; if (prog_ctr !== 12'h000 || running !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: got pc=%h run=%b want 000/0", prog_ctr, running); end
  endtask

  task automatic test_random;
    logic s, st, be, tk, h;
    logic [W-1:0] tg;
    for (int i = 0; i < 250; i++) begin
      s  = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 4) == 0);
      be = ($urandom_range(0, 2) == 0);
      tk = $urandom_range(0, 1) == 1;
      h  = ($urandom_range(0, 29) == 0);
      tg = W'($urandom);
      step(s, st, be, tk, tg, h);
      checks++; if (prog_ctr !== W'(m_pc)) begin errors++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, prog_ctr, W'(m_pc)); end
      checks++; if (running !== (m_state == 1)) begin errors++; $display("FAIL rnd_running[%0d]: got %b want %b", i, running, m_state == 1); end
      checks++; if (done !== (m_state == 2)) begin errors++; $display("FAIL rnd_done[%0d]: got %b want %b", i, done, m_state == 2); end
`ifdef PROG_CTR_PERF_EN
      checks++; if (cycle_cnt !== 32'(m_cyc) || br_taken_cnt !== 16'(m_br)) begin
        errors++; $display("FAIL rnd_perf[%0d]: got %0d/%0d want %0d/%0d", i, cycle_cnt, br_taken_cnt, m_cyc, m_br); end
`endif
    end
  endtask

`ifdef PROG_CTR_PERF_EN
  task automatic test_perf;
    // get to HALT, then restart so counting begins from a clean start
    if (m_state == 1) step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    checks++; if (cycle_cnt !== 32'd0 || br_taken_cnt !== 16'd0) begin
      errors++; $display("FAIL perf_clear: got %0d/%0d want 0/0", cycle_cnt, br_taken_cnt); end
    step(1'b0, 1'b0, 1'b1, 1'b1, 12'h010, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 12'h010, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 12'hFFE, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 12'h033, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 12'h003, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    checks++; if (cycle_cnt !== 32'd10 || br_taken_cnt !== 16'd3) begin
      errors++; $display("FAIL perf_count: got %0d/%0d want 10/3", cycle_cnt, br_taken_cnt); end
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    checks++; if (cycle_cnt !== 32'd0 || br_taken_cnt !== 16'd0) begin
      errors++; $display("FAIL perf_restart: got %0d/%0d want 0/0", cycle_cnt, br_taken_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_start_seq();
    test_branches();
    test_wrap();
    test_priority();
    test_async_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    test_random();
`ifdef PROG_CTR_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_prog_ctr_fsm

// File: doc/prog_ctr_fsm.md
Name: prog_ctr_fsm

Overview:
- Program-counter stage that consumes the signed branch offset produced by the branch-target lookup (`target`, WIDTH bits, two's complement).
- Holds the fetch address, advances by 1 each instruction, applies PC-relative taken branches, and sequences start/run/halt for the core.
- Output PC drives instruction-memory address. The done flag goes to the testbench/top level.

Parameters:
- WIDTH, 12: PC and offset width in bits; all PC arithmetic is modulo 2**WIDTH.
- START_ADDR, 0: PC value loaded on reset and on each accepted start.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level/pulse request to begin execution from START_ADDR.
- stall  input  1  hold PC and state this cycle (e.g. multi-cycle memory op).
- branch_en  input  1  current instruction is a conditional branch.
- taken  input  1  branch condition result from ALU flags; ignored unless branch_en.
- target  input  WIDTH  signed relative offset from the lookup stage.
- halt  input  1  current instruction is the halt opcode.
- prog_ctr  output  WIDTH  current fetch address.
- running  output  1  high while in RUN.
- done  output  1  high while in HALT.

Behaviour:
- States: IDLE, RUN, HALT.
- Reset (async assert, synchronous-to-clk deassert is the top level's job):
  - state=IDLE, prog_ctr=START_ADDR, running=0, done=0.
- IDLE:
  - prog_ctr holds START_ADDR.
  - start=1 -> RUN next edge; prog_ctr stays START_ADDR, so the first instruction fetched is START_ADDR.
- RUN, per rising edge, priority high to low:
  1. stall=1: hold prog_ctr and state; halt, branch and start are ignored that cycle.
  2. halt=1: -> HALT; prog_ctr holds the halt instruction's address. Halt beats a simultaneous taken branch.
  3. branch_en=1 and taken=1: prog_ctr <= prog_ctr + target (WIDTH-bit add, carry discarded).
     - target=0 holds PC (spin).
     - target=all-ones steps back 1.
  4. Otherwise: prog_ctr <= prog_ctr + 1.
- Wrap-around: 2**WIDTH-1 + 1 -> 0; 0 + (-5) -> 2**WIDTH-5. No error flag.
- start is ignored in RUN.
- HALT:
  - done=1, prog_ctr frozen.
  - start=1 -> RUN with prog_ctr<=START_ADDR and done cleared on that edge.
  - stall is ignored.
- Output timing: running/done are registered state decodes. Latency from start to running=1 is 1 cycle. PC update latency is 1 cycle (next-PC visible the cycle after the decision inputs).
- Reset mid-RUN: immediately IDLE/START_ADDR regardless of pending branch.
- Inputs are sampled only on clk; branch/halt are qualified by state==RUN.

Optional Feature:
- Macro: PROG_CTR_PERF_EN.
- When defined, adds:
  - output cycle_cnt (32): counts edges spent in RUN including stalls.
  - output br_taken_cnt (16): counts applied taken branches.
- Both counters reset to 0 on rst_n and on each accepted start; both saturate at all-ones.
- Without the macro these ports and registers do not exist; core behaviour is identical.

Decomposition:
- Package prog_ctr_pkg holds:
  - state enum pc_state_t {IDLE, RUN, HALT} (2-bit).
  - default PC_W=12.
  - localparam PC_INC=1.
- One natural sub-module: pc_next_calc, a combinational next-PC mux/adder (inputs prog_ctr, target, branch/taken/halt/stall, state; output next value). The FSM and registers stay in prog_ctr_fsm.

Test Plan:
- Reset/start: assert rst_n=0 mid-cycle -> prog_ctr=0, running=0, done=0 asynchronously; pulse start -> running=1 next edge, PC sequence 0,0,1,2,3 over following edges.
- Taken backward branch: PC=10, branch_en=1, taken=1, target=-5 (0xFFB) -> next PC=5. With taken=0 -> 11.
- Forward and zero offsets: PC=4, target=20 taken -> 24. PC=24, target=0 taken -> stays 24 for each such cycle. target=0xFFF taken at PC=4 -> 3.
- Wrap: PC=0xFFF sequential -> 0x000. PC=0x002 taken target=-5 -> 0xFFD.
- Priority: stall=1 with halt=1 and taken branch -> PC and state unchanged. Next cycle halt=1 plus taken branch -> HALT, done=1, PC unchanged. start in HALT -> PC=0, running=1, done=0.
- PROG_CTR_PERF_EN build: 10 RUN cycles including 2 stalls and 3 taken branches -> cycle_cnt=10, br_taken_cnt=3. Restart clears both to 0.
